// File: rtl/rst_seq_xil7series_if.sv
// rst_seq_xil7series_if: PLL-lock/button inputs and sequenced reset outputs of the reset sequencer.
interface rst_seq_xil7series_if;
    logic       pll_locked;
    logic       btn_rst;
    logic       rst_periph_n;
    logic       rst_core_n;
    logic       seq_done;
    logic [1:0] rst_cause;
    modport master (output pll_locked, btn_rst, input rst_periph_n, rst_core_n, seq_done, rst_cause);
    modport slave  (input pll_locked, btn_rst, output rst_periph_n, rst_core_n, seq_done, rst_cause);
endinterface

// File: rtl/rst_seq_xil7series.sv
// rst_seq_xil7series: PLL-lock driven peripheral/core reset sequencer with cause tracking.
// Optional button debounce enabled by defining RST_SEQ_DEBOUNCE_EN.
module rst_seq_xil7series #(
    parameter int STRETCH_CYCLES  = 1024,
    parameter int CORE_DELAY      = 16,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    rst_seq_xil7series_if.slave   bus
);
    localparam logic [2:0] RESET     = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STRETCH   = 3'd2;
    localparam logic [2:0] PERIPH_UP = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;
    localparam int MAXC = (STRETCH_CYCLES > CORE_DELAY) ? STRETCH_CYCLES : CORE_DELAY;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] S_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CORE_DELAY - 1);

    if (STRETCH_CYCLES < 1 || CORE_DELAY < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("rst_seq_xil7series: all cycle parameters must be >= 1");
    end

    logic       lock_m_q, lock_s_q, btn_m_q, btn_s_q, btn_d;
    logic [2:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;
    logic       periph_q, core_q, fault;

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            lock_m_q <= 1'b0;
            lock_s_q <= 1'b0;
            btn_m_q  <= 1'b0;
            btn_s_q  <= 1'b0;
        end else begin
            lock_m_q <= bus.pll_locked;
            lock_s_q <= lock_m_q;
            btn_m_q  <= bus.btn_rst;
            btn_s_q  <= btn_m_q;
        end
    end

`ifdef RST_SEQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] dcnt_q;
    logic          btn_d_q;
    // btn_d follows btn_s only after a full run of disagreeing samples
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            dcnt_q  <= '0;
            btn_d_q <= 1'b0;
        end else if (btn_s_q == btn_d_q) begin
            dcnt_q  <= '0;
        end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            dcnt_q  <= '0;
            btn_d_q <= btn_s_q;
        end else begin
            dcnt_q  <= dcnt_q + 1'b1;
        end
    end
    assign btn_d = btn_d_q;
`else
    assign btn_d = btn_s_q;
`endif

    assign fault = ~lock_s_q | btn_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            RESET:     state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                state_d = fault ? WAIT_LOCK : STRETCH;
                cnt_d   = '0;
            end
            STRETCH:   begin
                state_d = (cnt_q == S_LAST) ? PERIPH_UP : STRETCH;
                cnt_d   = (cnt_q == S_LAST) ? '0 : cnt_q + 1'b1;
            end
            PERIPH_UP: begin
                state_d = (cnt_q == C_LAST) ? RUN : PERIPH_UP;
                cnt_d   = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
            end
            RUN:       state_d = RUN;
            default:   state_d = RESET;
        endcase
        // A fault anywhere past WAIT_LOCK aborts the sequence and records why
        if (fault && (state_q == STRETCH || state_q == PERIPH_UP || state_q == RUN)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            cause_d = {btn_d, ~lock_s_q};
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q  <= RESET;
            cnt_q    <= '0;
            cause_q  <= 2'b00;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            periph_q <= (state_d == PERIPH_UP) || (state_d == RUN);
            core_q   <= state_d == RUN;
        end
    end

    assign bus.rst_periph_n = periph_q;
    assign bus.rst_core_n   = core_q;
    assign bus.seq_done     = periph_q & core_q;
    assign bus.rst_cause    = cause_q;
endmodule
